// File: rtl/riscv_pkg.sv
// Shared definitions for the core and its instruction-memory loader.
//   XLEN           machine word width
//   NOP_INSTR      canonical RISC-V NOP (addi x0, x0, 0)
//   loader_state_t imem_loader FSM states
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    LD_WAIT,
    LD_RUN,
    LD_LOAD
  } loader_state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: collects a little-endian byte stream into 32-bit words.
// The fourth byte is not stored; it is forwarded straight into the top lane of
// word_o so that the word can be written on the same edge it completes.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset (clears the lane counter)
//   clear_i      in   restart at lane 0 (start of a new load)
//   byte_vld_i   in   byte_i is transferred this cycle
//   byte_i       in   incoming byte
//   word_o       out  assembled word {byte_i, lane2, lane1, lane0}
//   word_valid_o out  word_o is complete (fourth byte being transferred)
module word_packer
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            byte_vld_i,
  input  logic [7:0]      byte_i,
  output logic [XLEN-1:0] word_o,
  output logic            word_valid_o
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] lanes_q;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (clear_i) begin
      byte_cnt_d = 2'd0;
    end else if (byte_vld_i) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= 2'd0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Lane storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (byte_vld_i && (byte_cnt_q != 2'd3)) begin
      lanes_q[8*byte_cnt_q +: 8] <= byte_i;
    end
  end

  assign word_o       = {byte_i, lanes_q};
  assign word_valid_o = byte_vld_i && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: instruction memory for the single-cycle core with a byte-stream
// program loader. instr is read combinationally from pc; a load packs
// little-endian bytes into words and holds the core until it completes.
// Build option: define IMEM_MISALIGN_TRAP_EN to return NOP and raise pc_fault
// on a misaligned pc; otherwise pc[1:0] is ignored and pc_fault is tied low.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   pc          in   byte address from the core
//   instr       out  instruction word at pc (zero latency)
//   load_start  in   pulse: begin a load (ignored while loading)
//   load_words  in   words to load, clamped to DEPTH_WORDS
//   load_valid  in   load_data is valid
//   load_data   in   program byte, LSB of each word first
//   load_ready  out  loader accepts a byte this cycle
//   load_done   out  one-cycle pulse after the last word is written
//   core_hold   out  core must stay stalled
//   pc_fault    out  misaligned pc (trap build only)
module imem_loader
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter bit BOOT_HOLD   = 1'b1,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  input  logic            load_start,
  input  logic [AW:0]     load_words,
  input  logic            load_valid,
  input  logic [7:0]      load_data,
  output logic            load_ready,
  output logic            load_done,
  output logic            core_hold,
  output logic            pc_fault
);

  localparam loader_state_t RST_STATE = BOOT_HOLD ? LD_WAIT : LD_RUN;
  localparam logic [AW:0]   DEPTH_L   = DEPTH_WORDS[AW:0];

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  loader_state_t   state_q, state_d;
  logic [AW:0]     len_q, len_d;
  logic [AW:0]     word_cnt_q, word_cnt_d;
  logic            done_q, done_d;
  logic [AW:0]     len_sel;
  logic            pk_clear;
  logic            byte_xfer;
  logic [XLEN-1:0] pk_word;
  logic            pk_word_valid;
  logic [AW-1:0]   rd_idx;
  logic            unused_pc;

  assign len_sel   = (load_words > DEPTH_L) ? DEPTH_L : load_words;
  assign pk_clear  = load_start && (state_q != LD_LOAD);
  assign byte_xfer = load_valid && load_ready;

  word_packer u_packer (
    .clk          (clk),
    .rst          (reset),
    .clear_i      (pk_clear),
    .byte_vld_i   (byte_xfer),
    .byte_i       (load_data),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      LD_WAIT, LD_RUN: begin
        if (load_start) begin
          state_d    = LD_LOAD;
          len_d      = len_sel;
          word_cnt_d = '0;
        end
      end
      LD_LOAD: begin
        if (len_q == '0) begin
          state_d = LD_RUN;
          done_d  = 1'b1;
        end else if (pk_word_valid) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == len_q - 1'b1) begin
            state_d = LD_RUN;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RST_STATE;
      len_q      <= '0;
      word_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      done_q     <= done_d;
    end
  end

  // Program contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (pk_word_valid) begin
      mem[word_cnt_q[AW-1:0]] <= pk_word;
    end
  end

  // A zero-length load must not accept bytes during its single LOAD cycle.
  assign load_ready = (state_q == LD_LOAD) && (len_q != '0);
  assign load_done  = done_q;
  assign core_hold  = (state_q != LD_RUN);

  assign rd_idx    = pc[AW+1:2];
  assign unused_pc = ^{pc[XLEN-1:AW+2], pc[1:0]};

`ifdef IMEM_MISALIGN_TRAP_EN
  assign pc_fault = (pc[1:0] != 2'b00);
  assign instr    = pc_fault ? NOP_INSTR : mem[rd_idx];
`else
  assign pc_fault = 1'b0;
  assign instr    = mem[rd_idx];
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  import riscv_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic        load_start = 1'b0;
  logic [8:0]  load_words = '0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = '0;
  logic        load_ready;
  logic        load_done;
  logic        core_hold;
  logic        pc_fault;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  logic [7:0]  lb[$];
  int          n_cmp = 0;
  int          n_err = 0;

  imem_loader #(.DEPTH_WORDS(DEPTH), .BOOT_HOLD(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .instr      (instr),
    .load_start (load_start),
    .load_words (load_words),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .core_hold  (core_hold),
    .pc_fault   (pc_fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_model(input int a);
    exp_t e;
    e.addr = a;
    e.data = model[a];
    sb.push_back(e);
  endtask

  // Pop every expected word and compare it with the combinational read port.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e  = sb.pop_front();
      pc = 32'(e.addr) << 2;
      #1;
      check_eq($sformatf("instr[%0d]", e.addr), instr, e.data);
    end
  endtask

  task automatic rand_bytes(input int n);
    lb.delete();
    for (int i = 0; i < n; i++) lb.push_back(8'($urandom_range(0, 255)));
  endtask

  // Issue load_start, then stream nbytes from lb. Each completed word is
  // pushed to the scoreboard as it is handed to the DUT.
  task automatic do_load(input int nwords, input int nbytes, input bit toggle, input bit expect_done);
    int          sent;
    int          cyc;
    logic [31:0] w;
    sent = 0;
    cyc  = 0;
    w    = '0;
    @(negedge clk);
    load_start = 1'b1;
    load_words = 9'(nwords);
    @(negedge clk);
    load_start = 1'b0;
    while (sent < nbytes && cyc < 5000) begin
      if (toggle && (cyc % 2 == 1)) begin
        load_valid = 1'b0;
      end else begin
        load_valid = 1'b1;
        load_data  = lb[sent];
      end
      #1;
      if (load_valid && load_ready) begin
        w[8*(sent%4) +: 8] = lb[sent];
        if (sent % 4 == 3) begin
          model[sent/4] = w;
          push_model(sent/4);
        end
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    load_valid = 1'b0;
    check_eq("bytes_sent", 32'(sent), 32'(nbytes));
    if (expect_done) begin
      #1;
      check_eq("done_pulse", 32'(load_done), 32'd1);
      check_eq("hold_fall", 32'(core_hold), 32'd0);
      @(negedge clk);
      #1;
      check_eq("done_once", 32'(load_done), 32'd0);
    end
  endtask

  initial begin
    int waited;

    // 1: reset state, then stay in WAIT without a load_start
    repeat (3) @(negedge clk);
    check_eq("rst_hold", 32'(core_hold), 32'd1);
    check_eq("rst_ready", 32'(load_ready), 32'd0);
    check_eq("rst_done", 32'(load_done), 32'd0);
    reset = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hAA;
    repeat (4) @(negedge clk);
    load_valid = 1'b0;
    check_eq("wait_hold", 32'(core_hold), 32'd1);
    check_eq("wait_ready", 32'(load_ready), 32'd0);

    // 2: two-word load, continuous valid
    lb = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_load(2, 8, 1'b0, 1'b1);
    check_eq("exp_w0", model[0], 32'h0000_0013);
    check_eq("exp_w1", model[1], 32'h0010_0093);
    drain();
    pc = 32'd4;
    #1;
    check_eq("pc4_instr", instr, 32'h0010_0093);

    // 3: overwrite with random words, then reload with valid toggling
    rand_bytes(12);
    do_load(3, 12, 1'b0, 1'b1);
    drain();
    lb = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    do_load(2, 8, 1'b1, 1'b1);
    push_model(2);
    drain();

    // 4: zero-length load finishes without writes
    @(negedge clk);
    load_start = 1'b1;
    load_words = 9'd0;
    @(negedge clk);
    load_start = 1'b0;
    waited = 0;
    while (!load_done && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    check_eq("zero_done", 32'(load_done), 32'd1);
    check_eq("zero_hold", 32'(core_hold), 32'd0);
    for (int i = 0; i < 3; i++) push_model(i);
    drain();

    // Oversized request is clamped to the full depth
    rand_bytes(4*DEPTH);
    do_load(300, 4*DEPTH, 1'b0, 1'b1);
    drain();

    // 5: reset after six bytes of a two-word load
    rand_bytes(8);
    do_load(2, 6, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("midrst_hold", 32'(core_hold), 32'd1);
    check_eq("midrst_ready", 32'(load_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    push_model(0);
    push_model(1);
    drain();
    @(negedge clk);
    check_eq("post_rst_hold", 32'(core_hold), 32'd1);
    rand_bytes(4);
    do_load(1, 4, 1'b0, 1'b1);
    push_model(1);
    drain();

    // 6: address wrap and misaligned pc
    pc = 32'h0000_0404;
    #1;
    check_eq("wrap_instr", instr, model[1]);
    check_eq("wrap_fault", 32'(pc_fault), 32'd0);
    pc = 32'h0000_0402;
    #1;
`ifdef IMEM_MISALIGN_TRAP_EN
    check_eq("mis_instr", instr, NOP_INSTR);
    check_eq("mis_fault", 32'(pc_fault), 32'd1);
`else
    check_eq("mis_instr", instr, model[0]);
    check_eq("mis_fault", 32'(pc_fault), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
